modulo_n_sequence_checker: RTL and testbench
============================================

# modulo_n_sequence_checker

Receive-side companion to the modulo-N counter. It samples an 8-bit counter stream and checks that each valid sample is the previous value plus one, modulo N. It locks onto the sequence after a run of correct increments, then reports mismatches and wraps. Typical use is as a monitor on counter outputs in benches and in on-chip self-check logic.

## Interface
- WIDTH, 8: width of the observed counter value
- N, 10: modulus; legal values are 0..N-1; constraint 2 <= N <= 2^WIDTH
- LOCK_COUNT, 3: consecutive correct increments required to lock; must be >= 1
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; while low, all state and outputs are forced to reset values
- valid  input  1  counter carries a sample this cycle
- counter  input  WIDTH  observed counter value
- clear  input  1  synchronous clear of err_count and wrap_count; does not change state
- locked  output  1  checker is in LOCKED
- expected  output  WIDTH  next value the checker expects: (ref+1) mod N; 0 in IDLE
- mismatch  output  1  one-cycle pulse when a LOCKED-state sample fails the check
- wrap_pulse  output  1  one-cycle pulse when a LOCKED-state step N-1 -> 0 is accepted
- err_count  output  16  mismatch count; saturates at 0xFFFF
- wrap_count  output  16  accepted wrap count; saturates at 0xFFFF

## Operation
- Internal state:
  - ref: last accepted sample, WIDTH bits
  - run: count of correct increments, 0..LOCK_COUNT
  - FSM with states IDLE, ACQUIRE and LOCKED
- A sample is "in range" if counter < N.
- A sample is "good" if it is in range and equals (ref+1) mod N. Wrap is computed explicitly: if ref == N-1, the next value is 0. No reliance on WIDTH overflow.
- valid low: state, ref, run and counters hold; mismatch and wrap_pulse are 0.
- IDLE:
  - Valid, in-range sample: ref <= counter, run <= 0, go to ACQUIRE.
  - Out-of-range sample: stay in IDLE.
- ACQUIRE:
  - Good sample: ref <= counter, run <= run+1. If run+1 == LOCK_COUNT, go to LOCKED.
  - In-range but not good: ref <= counter, run <= 0, stay in ACQUIRE (re-seed).
  - Out-of-range: go to IDLE, run <= 0.
  - No mismatch pulses or err_count changes in this state.
- LOCKED:
  - Good sample: ref <= counter. If ref was N-1, pulse wrap_pulse and increment wrap_count (saturating).
  - Bad sample: pulse mismatch and increment err_count (saturating). If the sample is in range, ref <= counter, run <= 0 and go to ACQUIRE. If out of range, go to IDLE.
- clear:
  - Zeroes err_count and wrap_count.
  - If clear coincides with an increment, clear wins (result 0).
  - The mismatch and wrap_pulse pulses still fire in that cycle.
- Saturation: at 0xFFFF, further events leave the counter at 0xFFFF. No rollover.

## Timing
- All outputs are registered. The response to the sample presented at edge k is visible after edge k, for one full cycle.
- Latency: one cycle from sample to locked, mismatch, wrap_pulse, expected and counter updates.
- Lock time: a fresh in-range stream locks after 1 + LOCK_COUNT valid samples. With the defaults, locked rises after the 4th sample.
- Reset values while reset is low: state IDLE, ref 0, run 0, locked 0, expected 0, mismatch 0, wrap_pulse 0, err_count 0, wrap_count 0.
- Reset takes effect immediately (asynchronous), including mid-lock and mid-pulse. Release of reset is synchronized to clk by the integrator.
- Source counter resetting to 0 mid-stream while LOCKED: this is a mismatch unless expected is 0. The checker re-acquires from 0.
- Back-to-back valid samples are supported every cycle. Gaps (valid low) are transparent.

## Test plan
- Reset: hold reset low for 2 cycles with valid=1 and counter=5. Required: all outputs 0 throughout. Release and send no samples: outputs stay 0.
- Acquire/lock: valid every cycle with values 0,1,2,3. Required: locked=1 after the 4th edge; expected=4; err_count=0. Insert valid=0 gaps between samples: same result.
- Wrap: locked, feed 7,8,9,0,1. Required:
  - wrap_pulse high exactly one cycle, after the sample 0
  - wrap_count=1
  - expected=2 at the end
  - locked stays 1 throughout
- Mismatch and re-lock: locked with expected=5, feed 7. Required:
  - mismatch pulses one cycle
  - err_count=1, locked=0, expected=8
  - then feed 8,9,0: locked=1 again; wrap_count unchanged (the wrap occurred in ACQUIRE)
- Out of range: locked, feed 12. Required: mismatch pulses, err_count increments, state IDLE, expected=0. Then feed 3: no pulse, expected=4, locked=0.
- Clear and reset races:
  - Assert clear in the same cycle as a LOCKED mismatch. Required: mismatch pulses, err_count=0.
  - Preload err_count to 0xFFFF via repeated mismatches (or force), then cause another mismatch. Required: err_count stays 0xFFFF.
  - Assert reset mid-lock between edges. Required: all outputs 0 before the next edge.

Source files
------------

// File: rtl/modulo_n_sequence_checker.sv
// modulo_n_sequence_checker
// Watches a modulo-N counter stream and checks that every valid sample is the
// previous accepted sample plus one (mod N). Locks after LOCK_COUNT correct
// increments, then flags mismatches and counts accepted wraps.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | no reference yet; waiting for an in-range sample to seed ref
//   S_ACQUIRE | seeded; counting consecutive good increments toward lock
//   S_LOCKED  | tracking; bad samples pulse mismatch, N-1 -> 0 pulses wrap
module modulo_n_sequence_checker #(
  parameter int WIDTH      = 8,
  parameter int N          = 10,
  parameter int LOCK_COUNT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_counter,
  input  logic             i_clear,
  output logic             o_locked,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_mismatch,
  output logic             o_wrap_pulse,
  output logic [15:0]      o_err_count,
  output logic [15:0]      o_wrap_count
);

  localparam int               RUN_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(N - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ref;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic [WIDTH-1:0] r_expected;
  logic             r_mismatch;
  logic             r_wrap_pulse;
  logic [15:0]      r_err_count;
  logic [15:0]      r_wrap_count;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_ref_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_mismatch_nxt;
  logic             w_wrap_nxt;
  logic [15:0]      w_err_nxt;
  logic [15:0]      w_wrap_cnt_nxt;
  logic [WIDTH-1:0] w_expected_nxt;
  logic             w_in_range;
  logic             w_good;

  // Wrap is explicit so non-power-of-two N never relies on WIDTH overflow.
  function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] v);
    return (v == LAST) ? '0 : v + WIDTH'(1);
  endfunction

  assign w_in_range = (32'(i_counter) < 32'(N));
  assign w_good     = w_in_range && (i_counter == f_inc(r_ref));

  // Next-state, pulse and counter update decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_ref_nxt      = r_ref;
    w_run_nxt      = r_run;
    w_mismatch_nxt = 1'b0;
    w_wrap_nxt     = 1'b0;

    if (i_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_in_range) begin
            w_ref_nxt   = i_counter;
            w_run_nxt   = '0;
            w_state_nxt = S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (w_good) begin
            w_ref_nxt = i_counter;
            w_run_nxt = r_run + RUN_W'(1);
            if (r_run == RUN_LAST) w_state_nxt = S_LOCKED;
          end else if (w_in_range) begin
            w_ref_nxt = i_counter;
            w_run_nxt = '0;
          end else begin
            w_run_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_LOCKED: begin
          if (w_good) begin
            w_ref_nxt  = i_counter;
            w_wrap_nxt = (r_ref == LAST);
          end else begin
            w_mismatch_nxt = 1'b1;
            w_run_nxt      = '0;
            if (w_in_range) begin
              w_ref_nxt   = i_counter;
              w_state_nxt = S_ACQUIRE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_run_nxt   = '0;
        end
      endcase
    end

    // Clear beats a same-cycle increment; the pulses themselves still fire.
    if (i_clear)
      w_err_nxt = '0;
    else if (w_mismatch_nxt && (r_err_count != 16'hFFFF))
      w_err_nxt = r_err_count + 16'd1;
    else
      w_err_nxt = r_err_count;

    if (i_clear)
      w_wrap_cnt_nxt = '0;
    else if (w_wrap_nxt && (r_wrap_count != 16'hFFFF))
      w_wrap_cnt_nxt = r_wrap_count + 16'd1;
    else
      w_wrap_cnt_nxt = r_wrap_count;

    w_expected_nxt = (w_state_nxt == S_IDLE) ? '0 : f_inc(w_ref_nxt);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ref        <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_expected   <= '0;
      r_mismatch   <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ref        <= w_ref_nxt;
      r_run        <= w_run_nxt;
      r_locked     <= (w_state_nxt == S_LOCKED);
      r_expected   <= w_expected_nxt;
      r_mismatch   <= w_mismatch_nxt;
      r_wrap_pulse <= w_wrap_nxt;
      r_err_count  <= w_err_nxt;
      r_wrap_count <= w_wrap_cnt_nxt;
    end
  end

  assign o_locked     = r_locked;
  assign o_expected   = r_expected;
  assign o_mismatch   = r_mismatch;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_err_count  = r_err_count;
  assign o_wrap_count = r_wrap_count;

endmodule

// File: tb/tb_modulo_n_sequence_checker.sv
// Directed bench for modulo_n_sequence_checker (WIDTH=8, N=10, LOCK_COUNT=3).
module tb_modulo_n_sequence_checker;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  counter;
  logic        clear;
  logic        locked;
  logic [7:0]  expected;
  logic        mismatch;
  logic        wrap_pulse;
  logic [15:0] err_count;
  logic [15:0] wrap_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic        clr;
    logic        e_locked;
    logic [7:0]  e_expected;
    logic        e_mm;
    logic        e_wp;
    logic [15:0] e_err;
    logic [15:0] e_wc;
    string       name;
  } vec_t;

  vec_t vecs[$];

  modulo_n_sequence_checker #(.WIDTH(8), .N(10), .LOCK_COUNT(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_counter    (counter),
    .i_clear      (clear),
    .o_locked     (locked),
    .o_expected   (expected),
    .o_mismatch   (mismatch),
    .o_wrap_pulse (wrap_pulse),
    .o_err_count  (err_count),
    .o_wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [7:0] c, input logic clr,
                     input logic l, input logic [7:0] e, input logic m,
                     input logic w, input logic [15:0] ec, input logic [15:0] wc,
                     input string name);
    vec_t t;
    t.v = v; t.c = c; t.clr = clr;
    t.e_locked = l; t.e_expected = e; t.e_mm = m; t.e_wp = w;
    t.e_err = ec; t.e_wc = wc; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic l, input logic [7:0] e,
                     input logic m, input logic w, input logic [15:0] ec,
                     input logic [15:0] wc);
    checks++;
    if (locked !== l || expected !== e || mismatch !== m || wrap_pulse !== w ||
        err_count !== ec || wrap_count !== wc) begin
      errors++;
      $display("FAIL %s: got locked=%0b exp=%0d mm=%0b wp=%0b err=%0h wc=%0h, want locked=%0b exp=%0d mm=%0b wp=%0b err=%0h wc=%0h",
               name, locked, expected, mismatch, wrap_pulse, err_count, wrap_count,
               l, e, m, w, ec, wc);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    @(negedge clk);
    valid = v; counter = c; clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {valid, counter, clear} -> {locked, expected, mismatch, wrap, err, wrap_cnt}
    add(1,  10, 0, 0, 0, 0, 0, 0, 0, "idle_oor_N");
    add(1,   0, 0, 0, 1, 0, 0, 0, 0, "seed0");
    add(1,   1, 0, 0, 2, 0, 0, 0, 0, "acq1");
    add(0,   7, 0, 0, 2, 0, 0, 0, 0, "gap1");
    add(1,   2, 0, 0, 3, 0, 0, 0, 0, "acq2");
    add(0,   9, 0, 0, 3, 0, 0, 0, 0, "gap2");
    add(1,   3, 0, 1, 4, 0, 0, 0, 0, "lock");
    add(1,   4, 0, 1, 5, 0, 0, 0, 0, "locked4");
    add(1,   7, 0, 0, 8, 1, 0, 1, 0, "mm_inrange");
    add(1,   8, 0, 0, 9, 0, 0, 1, 0, "reacq8");
    add(1,   9, 0, 0, 0, 0, 0, 1, 0, "reacq9");
    add(1,   0, 0, 1, 1, 0, 0, 1, 0, "relock_wrap_acq");
    for (int i = 1; i <= 8; i++)
      add(1, 8'(i), 0, 1, 8'((i + 1) % 10), 0, 0, 1, 0, "run");
    add(1,   9, 0, 1, 0, 0, 0, 1, 0, "pre_wrap");
    add(1,   0, 0, 1, 1, 0, 1, 1, 1, "wrap");
    add(1,   1, 0, 1, 2, 0, 0, 1, 1, "post_wrap");
    add(1,  12, 0, 0, 0, 1, 0, 2, 1, "locked_oor");
    add(1,   3, 0, 0, 4, 0, 0, 2, 1, "reseed3");
    add(1,   4, 0, 0, 5, 0, 0, 2, 1, "acq4");
    add(1,   5, 0, 0, 6, 0, 0, 2, 1, "acq5");
    add(1,   6, 0, 1, 7, 0, 0, 2, 1, "lock6");
    add(1,   9, 1, 0, 0, 1, 0, 0, 0, "clear_vs_mm");
    add(1,  15, 0, 0, 0, 0, 0, 0, 0, "acq_oor");
    add(1,   5, 0, 0, 6, 0, 0, 0, 0, "seed5");
    add(1,   8, 0, 0, 9, 0, 0, 0, 0, "acq_reseed8");
    add(1,   9, 0, 0, 0, 0, 0, 0, 0, "acq9");
    add(1,   0, 0, 0, 1, 0, 0, 0, 0, "acq0");
    add(1,   1, 0, 1, 2, 0, 0, 0, 0, "lock1");

    // Reset held low with live stimulus: outputs must stay at reset values.
    rst_n = 1'b0; valid = 1'b1; counter = 8'd5; clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", 0, 0, 0, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].clr);
      chk(vecs[i].name, vecs[i].e_locked, vecs[i].e_expected, vecs[i].e_mm,
          vecs[i].e_wp, vecs[i].e_err, vecs[i].e_wc);
    end

    // Saturation: preload err_count at its ceiling, then cause one more mismatch.
    @(negedge clk);
    valid = 1'b0;
    force dut.r_err_count = 16'hFFFF;
    #1;
    release dut.r_err_count;
    drive(1, 8'd7, 0);
    chk("err_saturate", 0, 8, 1, 0, 16'hFFFF, 0);
    drive(1, 8'd8, 0);
    drive(1, 8'd9, 0);
    drive(1, 8'd0, 0);
    chk("relock_before_reset", 1, 1, 0, 0, 16'hFFFF, 0);

    // Asynchronous reset between edges while locked.
    @(negedge clk);
    valid = 1'b1; counter = 8'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midcycle", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("async_reset_held", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
